// File: rtl/lsu_ctrl.sv
// Load/store controller between the ALU address path and a word-wide, word-write-only data memory.
// Handles B/H/W loads with extension and sub-word stores via read-modify-write.
module lsu_ctrl #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic                     mem_WE,
    output logic [ADDRESS_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0]    mem_WD,
    input  logic [DATA_WIDTH-1:0]    mem_RD
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic                       r_we;
    logic [2:0]                 r_funct3;
    logic [1:0]                 r_off;
    logic [DATA_WIDTH-1:0]      r_wdata;
    logic [DATA_WIDTH-1:0]      r_rdata;
    logic                       r_err;
    logic [ADDRESS_WIDTH-1:0]   r_mem_a;
    logic [DATA_WIDTH-1:0]      r_mem_wd;
    logic                       w_accept;
    logic                       w_legal;

    function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] word,
                                                          input logic [1:0] off,
                                                          input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{(DATA_WIDTH-8){b[7]}}, b};
            3'b100:  return {{(DATA_WIDTH-8){1'b0}}, b};
            3'b001:  return {{(DATA_WIDTH-16){h[15]}}, h};
            3'b101:  return {{(DATA_WIDTH-16){1'b0}}, h};
            3'b010:  return word;
            default: return '0;
        endcase
    endfunction

    // Only the addressed byte/halfword lanes change; the rest keep the value read in RD.
    function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [DATA_WIDTH-1:0] old,
                                                          input logic [DATA_WIDTH-1:0] wd,
                                                          input logic [1:0] off,
                                                          input logic [2:0] f3);
        logic [DATA_WIDTH-1:0] m;
        m = old;
        if (f3[1:0] == 2'b00) begin
            m[{off, 3'b000} +: 8] = wd[7:0];
        end else begin
            m[{off[1], 4'b0000} +: 16] = wd[15:0];
        end
        return m;
    endfunction

    assign req_ready  = (r_state == S_IDLE);
    assign w_accept   = req_valid & req_ready & ~rst;
    assign resp_valid = (r_state == S_DONE) & ~rst;
    assign resp_err   = r_err & resp_valid;
    assign resp_rdata = r_rdata;
    assign mem_WE     = (r_state == S_WR) & ~rst;
    assign mem_A      = r_mem_a;
    assign mem_WD     = r_mem_wd;

    always_comb begin
        w_legal = 1'b0;
        case (req_funct3)
            3'b000:  w_legal = 1'b1;
            3'b001:  w_legal = ~req_addr[0];
            3'b010:  w_legal = (req_addr[1:0] == 2'b00);
            3'b100:  w_legal = ~req_we;
            3'b101:  w_legal = ~req_we & ~req_addr[0];
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_legal)                     w_next = S_DONE;
                    else if (!req_we)                 w_next = S_RD;
                    else if (req_funct3 == 3'b010)    w_next = S_WR;
                    else                              w_next = S_RD;
                end
            end
            S_RD:    w_next = r_we ? S_WR : S_DONE;
            S_WR:    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_off    <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_mem_a  <= '0;
            r_mem_wd <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_off    <= req_addr[1:0];
                r_wdata  <= req_wdata;
                r_err    <= ~w_legal;
                r_rdata  <= '0;
                r_mem_a  <= {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
                if (req_we && req_funct3 == 3'b010) begin
                    r_mem_wd <= req_wdata;
                end
            end
            // RD either finishes a load or captures the old word for a sub-word store.
            if (r_state == S_RD) begin
                if (r_we) begin
                    r_mem_wd <= store_merge(mem_RD, r_wdata, r_off, r_funct3);
                end else begin
                    r_rdata <= load_extend(mem_RD, r_off, r_funct3);
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: table-driven loads/stores/errors plus reset and back-to-back sequences.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_WE;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;

    logic [31:0] mem [0:63];
    logic        bd_we;
    logic [5:0]  bd_idx;
    logic [31:0] bd_data;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_WE     (mem_WE),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_RD     (mem_RD)
    );

    // Word memory model: combinational read, write at the rising edge.
    assign mem_RD = mem[mem_A[7:2]];
    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        else if (mem_WE) mem[mem_A[7:2]] <= mem_WD;
    end

    always @(posedge clk) begin
        if (req_valid && req_ready && !rst) acc_cnt = acc_cnt + 1;
    end

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input logic er,
                       input int lat, input int wec);
        vec_t v;
        v.name = n; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.exp_rd = rd; v.exp_err = er; v.exp_lat = lat; v.exp_we = wec;
        vt.push_back(v);
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = idx; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Issue one request and follow it to completion; lat counts cycles after the accept edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er, output int wecnt);
        lat = 0; rd = '0; er = 1'b0; wecnt = 0;
        @(negedge clk);
        chk("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (mem_WE) wecnt++;
            if (resp_valid) begin
                lat = k; rd = resp_rdata; er = resp_err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat;
        int          wec;
        int          nresp;
        logic [31:0] rd;
        logic        er;
        logic        seen;
        int          acc0;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = '0; req_wdata = '0;
        bd_we = 1'b0; bd_idx = '0; bd_data = '0;

        preload(6'd4, 32'h8899AABB);
        preload(6'd8, 32'h01020304);
        preload(6'd9, 32'h00000000);
        preload(6'd10, 32'h00000000);

        @(posedge clk); #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_we", {31'b0, mem_WE}, 32'd0);
        chk("rst_mem_a", mem_A, 32'd0);
        chk("rst_mem_wd", mem_WD, 32'd0);

        // A request presented during reset must not be taken.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(posedge clk); #1;
        chk("rst_req_not_accepted", {31'b0, req_ready}, 32'd1);
        chk("rst_req_no_resp", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b0;

        add("lw_10",   1'b0, 3'b010, 32'h10, 32'h0,        32'h8899AABB, 1'b0, 2, 0);
        add("lb_13",   1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF88, 1'b0, 2, 0);
        add("lbu_13",  1'b0, 3'b100, 32'h13, 32'h0,        32'h00000088, 1'b0, 2, 0);
        add("lh_12",   1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF8899, 1'b0, 2, 0);
        add("lhu_10",  1'b0, 3'b101, 32'h10, 32'h0,        32'h0000AABB, 1'b0, 2, 0);
        add("lb_10",   1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFBB, 1'b0, 2, 0);
        add("lbu_11",  1'b0, 3'b100, 32'h11, 32'h0,        32'h000000AA, 1'b0, 2, 0);
        add("sb_11",   1'b1, 3'b000, 32'h11, 32'hFFFFFF5A, 32'h0,        1'b0, 3, 1);
        add("lw_sb",   1'b0, 3'b010, 32'h10, 32'h0,        32'h88995ABB, 1'b0, 2, 0);
        add("sh_12",   1'b1, 3'b001, 32'h12, 32'hABCD1234, 32'h0,        1'b0, 3, 1);
        add("lw_sh",   1'b0, 3'b010, 32'h10, 32'h0,        32'h12345ABB, 1'b0, 2, 0);
        add("err_lw11",1'b0, 3'b010, 32'h11, 32'h0,        32'h0,        1'b1, 1, 0);
        add("err_sh13",1'b1, 3'b001, 32'h13, 32'h0000FFFF, 32'h0,        1'b1, 1, 0);
        add("err_f011",1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0);
        add("err_sbu", 1'b1, 3'b100, 32'h10, 32'h000000EE, 32'h0,        1'b1, 1, 0);
        add("lw_after",1'b0, 3'b010, 32'h10, 32'h0,        32'h12345ABB, 1'b0, 2, 0);
        add("sw_24",   1'b1, 3'b010, 32'h24, 32'hCAFEF00D, 32'h0,        1'b0, 2, 1);
        add("lw_24",   1'b0, 3'b010, 32'h24, 32'h0,        32'hCAFEF00D, 1'b0, 2, 0);

        foreach (vt[i]) begin
            issue(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, lat, rd, er, wec);
            chk({vt[i].name, "_rdata"}, rd, vt[i].exp_rd);
            chk({vt[i].name, "_err"}, {31'b0, er}, {31'b0, vt[i].exp_err});
            chk({vt[i].name, "_lat"}, lat, vt[i].exp_lat);
            chk({vt[i].name, "_we_cycles"}, wec, vt[i].exp_we);
        end
        chk("mem10_final", mem[4], 32'h12345ABB);

        // Reset during the WR cycle of a word store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_in_wr", {31'b0, mem_WE}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_we_forced_low", {31'b0, mem_WE}, 32'd0);
        chk("abort_no_resp_now", {31'b0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        seen = resp_valid;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            seen = seen | resp_valid;
        end
        chk("abort_no_resp", {31'b0, seen}, 32'd0);
        chk("abort_mem_kept", mem[8], 32'h01020304);
        issue(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, er, wec);
        chk("abort_lw_rdata", rd, 32'h01020304);
        chk("abort_lw_lat", lat, 2);

        // Back-to-back: valid held high across SW then LW to the same address.
        @(negedge clk);
        acc0 = acc_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h28; req_wdata = 32'h55AA55AA;
        @(posedge clk); #1;
        req_we = 1'b0;
        nresp = 0; wec = 0;
        for (int k = 1; k <= 12; k++) begin
            if (mem_WE) wec++;
            if (resp_valid) begin
                nresp++;
                if (nresp == 1) begin
                    chk("b2b_sw_lat", k, 2);
                end else begin
                    chk("b2b_lw_lat", k, 5);
                    chk("b2b_lw_rdata", resp_rdata, 32'h55AA55AA);
                    chk("b2b_lw_err", {31'b0, resp_err}, 32'd0);
                    req_valid = 1'b0;
                    break;
                end
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("b2b_resp_count", nresp, 2);
        chk("b2b_we_cycles", wec, 1);
        @(posedge clk); #1;
        chk("b2b_accepts", acc_cnt - acc0, 2);
        chk("b2b_idle_ready", {31'b0, req_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
